// File: rtl/ace_snoop_responder.sv
// ACE snooped-master responder: AC -> tag lookup -> CR -> optional CD line -> optional state update.
// One snoop in flight; every outgoing valid holds with a stable payload until its ready.
package ace_snoop_pkg;
    typedef struct packed {
        logic [63:0] addr;
        logic [2:0]  prot;
        logic [3:0]  snoop;
    } ac_chan_t;

    typedef struct packed {
        ac_chan_t ac;
        logic     ac_valid;
        logic     cr_ready;
        logic     cd_ready;
    } snoop_req_t;

    typedef struct packed {
        logic [63:0] data;
        logic        last;
    } cd_chan_t;

    typedef struct packed {
        logic       ac_ready;
        logic       cr_valid;
        logic [4:0] cr_resp;
        logic       cd_valid;
        cd_chan_t   cd;
    } snoop_resp_t;
endpackage

module ace_snoop_responder #(
    parameter int unsigned AddrWidth    = 64,
    parameter int unsigned DataWidth    = 64,
    parameter int unsigned BeatsPerLine = 4,
    parameter type snoop_req_t  = ace_snoop_pkg::snoop_req_t,
    parameter type snoop_resp_t = ace_snoop_pkg::snoop_resp_t
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  snoop_req_t           snoop_req_i,
    output snoop_resp_t          snoop_resp_o,
    output logic                 lookup_valid_o,
    output logic [AddrWidth-1:0] lookup_addr_o,
    input  logic                 lookup_ready_i,
    input  logic                 lookup_hit_i,
    input  logic                 lookup_dirty_i,
    input  logic                 lookup_shared_i,
    output logic                 data_req_o,
    input  logic                 data_valid_i,
    input  logic [DataWidth-1:0] data_i,
    output logic                 data_ready_o,
    output logic                 upd_valid_o,
    input  logic                 upd_ready_i,
    output logic [AddrWidth-1:0] upd_addr_o,
    output logic                 upd_invalidate_o,
    output logic                 upd_clear_dirty_o,
    output logic                 upd_set_shared_o
);
    localparam int unsigned OffBits = $clog2(DataWidth / 8 * BeatsPerLine);
    localparam int unsigned BeatW   = (BeatsPerLine > 1) ? $clog2(BeatsPerLine) : 1;
    localparam logic [AddrWidth-1:0] LineMask =
        ~((AddrWidth'(1) << OffBits) - AddrWidth'(1));
    localparam logic [BeatW-1:0] LastBeat = BeatW'(BeatsPerLine - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_RESP,
        S_DATA,
        S_UPDATE
    } state_e;

    state_e               state_q, state_d;
    logic [AddrWidth-1:0] addr_q, addr_d;
    logic [3:0]           snoop_q, snoop_d;
    logic [4:0]           cr_resp_q, cr_resp_d;
    logic                 inv_q, inv_d;
    logic                 clr_q, clr_d;
    logic                 set_q, set_d;
    logic [BeatW-1:0]     beat_q, beat_d;

    logic dt, pd, is_sh, wu, act_inv, act_clr, act_set;
    logic supported;
    logic beat_xfer, beat_last;
    logic unused_prot;

    assign unused_prot = ^snoop_req_i.ac.prot;

    always_comb begin
        supported = 1'b0;
        case (snoop_req_i.ac.snoop)
            4'b0000, 4'b0001, 4'b0010, 4'b0011,
            4'b0111, 4'b1000, 4'b1001, 4'b1101: supported = 1'b1;
            default:                            supported = 1'b0;
        endcase
    end

    // Response and cache actions for the latched code against the lookup result.
    always_comb begin
        dt      = 1'b0;
        pd      = 1'b0;
        is_sh   = 1'b0;
        act_inv = 1'b0;
        act_clr = 1'b0;
        act_set = 1'b0;
        case (snoop_q)
            4'b0000: begin
                dt = 1'b1; is_sh = 1'b1;
            end
            4'b0001, 4'b0011: begin
                dt = 1'b1; is_sh = 1'b1; pd = lookup_dirty_i;
                act_set = 1'b1; act_clr = lookup_dirty_i;
            end
            4'b0010: begin
                dt = 1'b1; is_sh = 1'b1; act_set = 1'b1;
            end
            4'b0111: begin
                dt = 1'b1; pd = lookup_dirty_i; act_inv = 1'b1;
            end
            4'b1000: begin
                dt = lookup_dirty_i; pd = lookup_dirty_i; is_sh = 1'b1;
                act_clr = lookup_dirty_i;
            end
            4'b1001: begin
                dt = lookup_dirty_i; pd = lookup_dirty_i; act_inv = 1'b1;
            end
            4'b1101: act_inv = 1'b1;
            default: ;
        endcase
        wu = lookup_hit_i & ~lookup_shared_i;
        if (!lookup_hit_i) begin
            dt = 1'b0; pd = 1'b0; is_sh = 1'b0;
            act_inv = 1'b0; act_clr = 1'b0; act_set = 1'b0;
        end
    end

    assign beat_xfer = data_valid_i & snoop_req_i.cd_ready;
    assign beat_last = (beat_q == LastBeat);

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        snoop_d   = snoop_q;
        cr_resp_d = cr_resp_q;
        inv_d     = inv_q;
        clr_d     = clr_q;
        set_d     = set_q;
        beat_d    = beat_q;

        snoop_resp_o         = '0;
        snoop_resp_o.cr_resp = cr_resp_q;
        snoop_resp_o.cd.data = data_i;
        snoop_resp_o.cd.last = beat_last;
        lookup_valid_o       = 1'b0;
        data_req_o           = 1'b0;
        data_ready_o         = 1'b0;
        upd_valid_o          = 1'b0;

        case (state_q)
            S_IDLE: begin
                snoop_resp_o.ac_ready = 1'b1;
                if (snoop_req_i.ac_valid) begin
                    addr_d    = snoop_req_i.ac.addr & LineMask;
                    snoop_d   = snoop_req_i.ac.snoop;
                    cr_resp_d = '0;
                    inv_d     = 1'b0;
                    clr_d     = 1'b0;
                    set_d     = 1'b0;
                    state_d   = supported ? S_LOOKUP : S_RESP;
                end
            end
            S_LOOKUP: begin
                lookup_valid_o = 1'b1;
                if (lookup_ready_i) begin
                    cr_resp_d = {wu, is_sh, pd, 1'b0, dt};
                    inv_d     = act_inv;
                    clr_d     = act_clr;
                    set_d     = act_set;
                    state_d   = S_RESP;
                end
            end
            S_RESP: begin
                snoop_resp_o.cr_valid = 1'b1;
                if (snoop_req_i.cr_ready) begin
                    beat_d = '0;
                    if (cr_resp_q[0])                state_d = S_DATA;
                    else if (inv_q | clr_q | set_q)  state_d = S_UPDATE;
                    else                             state_d = S_IDLE;
                end
            end
            S_DATA: begin
                data_req_o            = 1'b1;
                snoop_resp_o.cd_valid = data_valid_i;
                data_ready_o          = snoop_req_i.cd_ready;
                if (beat_xfer) begin
                    beat_d = beat_q + BeatW'(1);
                    if (beat_last)
                        state_d = (inv_q | clr_q | set_q) ? S_UPDATE : S_IDLE;
                end
            end
            S_UPDATE: begin
                upd_valid_o = 1'b1;
                if (upd_ready_i) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign lookup_addr_o     = addr_q;
    assign upd_addr_o        = addr_q;
    assign upd_invalidate_o  = inv_q;
    assign upd_clear_dirty_o = clr_q;
    assign upd_set_shared_o  = set_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            snoop_q   <= '0;
            cr_resp_q <= '0;
            inv_q     <= 1'b0;
            clr_q     <= 1'b0;
            set_q     <= 1'b0;
            beat_q    <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            snoop_q   <= snoop_d;
            cr_resp_q <= cr_resp_d;
            inv_q     <= inv_d;
            clr_q     <= clr_d;
            set_q     <= set_d;
            beat_q    <= beat_d;
        end
    end
endmodule

// File: tb/tb_ace_snoop_responder.sv
// Directed bench for ace_snoop_responder: hand-computed CR codes, beat streams and updates.
`define CHK(tag, obs, exp) begin \
    checks++; \
    assert ((obs) === (exp)) else begin \
        errors++; \
        $error("FAIL %s observed=%0h expected=%0h", tag, (obs), (exp)); \
    end \
end

module tb_ace_snoop_responder;
    import ace_snoop_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    snoop_req_t  req;
    snoop_resp_t resp;
    logic        lookup_valid;
    logic [63:0] lookup_addr;
    logic        lookup_ready, hit, dirty, shared;
    logic        data_req, data_valid, data_ready;
    logic [63:0] data;
    logic        upd_valid, upd_ready;
    logic [63:0] upd_addr;
    logic        upd_inv, upd_clr, upd_set;
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    ace_snoop_responder dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .snoop_req_i      (req),
        .snoop_resp_o     (resp),
        .lookup_valid_o   (lookup_valid),
        .lookup_addr_o    (lookup_addr),
        .lookup_ready_i   (lookup_ready),
        .lookup_hit_i     (hit),
        .lookup_dirty_i   (dirty),
        .lookup_shared_i  (shared),
        .data_req_o       (data_req),
        .data_valid_i     (data_valid),
        .data_i           (data),
        .data_ready_o     (data_ready),
        .upd_valid_o      (upd_valid),
        .upd_ready_i      (upd_ready),
        .upd_addr_o       (upd_addr),
        .upd_invalidate_o (upd_inv),
        .upd_clear_dirty_o(upd_clr),
        .upd_set_shared_o (upd_set)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic send_ac(input logic [3:0] code, input logic [63:0] addr);
        req.ac.addr  = addr;
        req.ac.snoop = code;
        req.ac.prot  = 3'b010;
        req.ac_valid = 1'b1;
        #1;
        `CHK("ac_ready_idle", resp.ac_ready, 1'b1)
        tick;
        req.ac_valid = 1'b0;
    endtask

    task automatic do_lookup(input logic h, input logic d, input logic s,
                             input logic [63:0] exp_addr);
        hit = h; dirty = d; shared = s;
        lookup_ready = 1'b1;
        #1;
        `CHK("lookup_valid", lookup_valid, 1'b1)
        `CHK("lookup_addr", lookup_addr, exp_addr)
        tick;
        lookup_ready = 1'b0;
    endtask

    task automatic do_resp(input logic [4:0] exp_resp, input int stall);
        req.cr_ready = 1'b0;
        #1;
        for (int i = 0; i < stall; i++) begin
            `CHK("cr_valid_stall", resp.cr_valid, 1'b1)
            `CHK("cr_resp_stall", resp.cr_resp, exp_resp)
            `CHK("ac_ready_busy", resp.ac_ready, 1'b0)
            tick;
        end
        `CHK("cr_valid", resp.cr_valid, 1'b1)
        `CHK("cr_resp", resp.cr_resp, exp_resp)
        req.cr_ready = 1'b1;
        tick;
        req.cr_ready = 1'b0;
    endtask

    task automatic do_beats(input logic [63:0] base, input int count, input int total);
        for (int k = 0; k < count; k++) begin
            data_valid   = 1'b1;
            data         = base + 64'(k);
            req.cd_ready = 1'b1;
            #1;
            `CHK("cd_valid", resp.cd_valid, 1'b1)
            `CHK("cd_data", resp.cd.data, base + 64'(k))
            `CHK("cd_last", resp.cd.last, (k == total - 1))
            `CHK("data_req", data_req, 1'b1)
            tick;
        end
    endtask

    task automatic do_upd(input logic inv, input logic clr, input logic set,
                          input logic [63:0] addr);
        #1;
        `CHK("upd_valid", upd_valid, 1'b1)
        `CHK("upd_inv", upd_inv, inv)
        `CHK("upd_clr", upd_clr, clr)
        `CHK("upd_set", upd_set, set)
        `CHK("upd_addr", upd_addr, addr)
        upd_ready = 1'b1;
        tick;
        upd_ready = 1'b0;
        #1;
        `CHK("upd_done_idle", resp.ac_ready, 1'b1)
        `CHK("upd_dropped", upd_valid, 1'b0)
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int  k;
        int  cyc;
        logic cdr;

        rst = 1'b1;
        req = '0;
        lookup_ready = 1'b0; hit = 1'b0; dirty = 1'b0; shared = 1'b0;
        data_valid = 1'b0; data = '0; upd_ready = 1'b0;
        tick;
        tick;
        rst = 1'b0;
        #1;
        checks++;
        if (resp.ac_ready !== 1'b1) begin
            errors++; $error("FAIL rst_ac_ready observed=%0h", resp.ac_ready);
        end
        checks++;
        if (resp.cr_valid !== 1'b0) begin
            errors++; $error("FAIL rst_cr_valid observed=%0h", resp.cr_valid);
        end
        checks++;
        if (resp.cr_resp !== 5'b00000) begin
            errors++; $error("FAIL rst_cr_resp observed=%0h", resp.cr_resp);
        end
        checks++;
        if (lookup_valid !== 1'b0) begin
            errors++; $error("FAIL rst_lookup_valid observed=%0h", lookup_valid);
        end
        checks++;
        if (data_req !== 1'b0) begin
            errors++; $error("FAIL rst_data_req observed=%0h", data_req);
        end
        checks++;
        if (data_ready !== 1'b0) begin
            errors++; $error("FAIL rst_data_ready observed=%0h", data_ready);
        end
        checks++;
        if (upd_valid !== 1'b0) begin
            errors++; $error("FAIL rst_upd_valid observed=%0h", upd_valid);
        end

        // ReadShared miss
        send_ac(4'b0001, 64'h1000);
        do_lookup(1'b0, 1'b0, 1'b0, 64'h1000);
        do_resp(5'b00000, 0);
        data_valid = 1'b1;
        #1;
        `CHK("miss_ac_ready", resp.ac_ready, 1'b1)
        `CHK("miss_cd_valid", resp.cd_valid, 1'b0)
        `CHK("miss_data_req", data_req, 1'b0)
        `CHK("miss_upd_valid", upd_valid, 1'b0)
        data_valid = 1'b0;

        // ReadShared hit dirty unshared
        send_ac(4'b0001, 64'h1048);
        do_lookup(1'b1, 1'b1, 1'b0, 64'h1040);
        do_resp(5'b11101, 0);
        do_beats(64'hA0, 4, 4);
        data_valid = 1'b0; req.cd_ready = 1'b0;
        do_upd(1'b0, 1'b1, 1'b1, 64'h1040);

        // CleanInvalid hit dirty unshared
        send_ac(4'b1001, 64'h2010);
        do_lookup(1'b1, 1'b1, 1'b0, 64'h2000);
        do_resp(5'b10101, 0);
        do_beats(64'hB0, 4, 4);
        data_valid = 1'b0; req.cd_ready = 1'b0;
        do_upd(1'b1, 1'b0, 1'b0, 64'h2000);

        // CleanInvalid on a clean shared hit: no data, invalidate only
        send_ac(4'b1001, 64'h2010);
        do_lookup(1'b1, 1'b0, 1'b1, 64'h2000);
        do_resp(5'b00000, 0);
        data_valid = 1'b1;
        #1;
        `CHK("ci_clean_cd_valid", resp.cd_valid, 1'b0)
        `CHK("ci_clean_data_req", data_req, 1'b0)
        data_valid = 1'b0;
        do_upd(1'b1, 1'b0, 1'b0, 64'h2000);

        // ReadUnique clean unshared, CR stalled, CD ready toggling, busy AC ignored
        send_ac(4'b0111, 64'h3038);
        do_lookup(1'b1, 1'b0, 1'b0, 64'h3020);
        req.ac_valid = 1'b1;
        do_resp(5'b10001, 5);
        req.ac_valid = 1'b0;
        k = 0; cyc = 0;
        data_valid = 1'b1;
        while (k < 4 && cyc < 20) begin
            cdr = cyc[0];
            req.cd_ready = cdr;
            data = 64'hC0 + 64'(k);
            #1;
            checks++;
            if (resp.cd_valid !== 1'b1) begin
                errors++; $error("FAIL ru_cd_valid observed=%0h", resp.cd_valid);
            end
            checks++;
            if (resp.cd.data !== 64'hC0 + 64'(k)) begin
                errors++; $error("FAIL ru_cd_data observed=%0h", resp.cd.data);
            end
            checks++;
            if (resp.cd.last !== (k == 3)) begin
                errors++; $error("FAIL ru_cd_last observed=%0h beat=%0d", resp.cd.last, k);
            end
            checks++;
            if (data_ready !== cdr) begin
                errors++; $error("FAIL ru_data_ready observed=%0h", data_ready);
            end
            tick;
            if (cdr) k++;
            cyc++;
        end
        #1;
        checks++;
        if (k !== 4) begin
            errors++; $error("FAIL ru_beat_count observed=%0d", k);
        end
        checks++;
        if (data_req !== 1'b0) begin
            errors++; $error("FAIL ru_data_done observed=%0h", data_req);
        end
        data_valid = 1'b0; req.cd_ready = 1'b0;
        do_upd(1'b1, 1'b0, 1'b0, 64'h3020);

        // ReadShared clean shared hit, reset after two beats
        send_ac(4'b0001, 64'h4000);
        do_lookup(1'b1, 1'b0, 1'b1, 64'h4000);
        do_resp(5'b01001, 0);
        do_beats(64'hD0, 2, 4);
        rst = 1'b1;
        data_valid = 1'b1; req.cd_ready = 1'b1;
        tick;
        rst = 1'b0;
        #1;
        checks++;
        if (resp.cd_valid !== 1'b0) begin
            errors++; $error("FAIL rstmid_cd_valid observed=%0h", resp.cd_valid);
        end
        checks++;
        if (data_req !== 1'b0) begin
            errors++; $error("FAIL rstmid_data_req observed=%0h", data_req);
        end
        checks++;
        if (upd_valid !== 1'b0) begin
            errors++; $error("FAIL rstmid_upd_valid observed=%0h", upd_valid);
        end
        checks++;
        if (resp.ac_ready !== 1'b1) begin
            errors++; $error("FAIL rstmid_ac_ready observed=%0h", resp.ac_ready);
        end
        data_valid = 1'b0; req.cd_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick;
            checks++;
            if (upd_valid !== 1'b0) begin
                errors++; $error("FAIL rstmid_no_upd observed=%0h", upd_valid);
            end
            checks++;
            if (resp.cr_valid !== 1'b0) begin
                errors++; $error("FAIL rstmid_no_cr observed=%0h", resp.cr_valid);
            end
        end

        // DVM: unsupported code skips lookup
        req.ac.addr = 64'h5000; req.ac.snoop = 4'b1111; req.ac_valid = 1'b1;
        #1;
        checks++;
        if (resp.ac_ready !== 1'b1) begin
            errors++; $error("FAIL dvm_ac_ready observed=%0h", resp.ac_ready);
        end
        tick;
        req.ac_valid = 1'b0;
        #1;
        checks++;
        if (lookup_valid !== 1'b0) begin
            errors++; $error("FAIL dvm_no_lookup observed=%0h", lookup_valid);
        end
        checks++;
        if (resp.cr_valid !== 1'b1) begin
            errors++; $error("FAIL dvm_cr_valid observed=%0h", resp.cr_valid);
        end
        checks++;
        if (resp.cr_resp !== 5'b00000) begin
            errors++; $error("FAIL dvm_cr_resp observed=%0h", resp.cr_resp);
        end
        req.cr_ready = 1'b1;
        tick;
        req.cr_ready = 1'b0;
        #1;
        checks++;
        if (resp.ac_ready !== 1'b1) begin
            errors++; $error("FAIL dvm_idle observed=%0h", resp.ac_ready);
        end
        checks++;
        if (lookup_valid !== 1'b0) begin
            errors++; $error("FAIL dvm_no_lookup_after observed=%0h", lookup_valid);
        end
        checks++;
        if (upd_valid !== 1'b0) begin
            errors++; $error("FAIL dvm_no_upd observed=%0h", upd_valid);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
